// File: rtl/controlador_porta.sv
// Sequential door-opener: multi-channel card readers with fixed priority,
// presence-held open window and lockout after repeated denied attempts.

module controlador_porta_borda (
  input  logic clk,
  input  logic rst,
  input  logic nivel,
  output logic ev
);
  logic q;

  always_ff @(posedge clk or posedge rst)
    if (rst) q <= 1'b0;
    else     q <= nivel;

  // cleared history means a card held through reset yields one event
  assign ev = nivel & ~q;
endmodule

module controlador_porta #(
  parameter int N_CANAIS   = 4,
  parameter int T_ABERTA   = 50,
  parameter int T_BLOQUEIO = 200,
  parameter int MAX_FALHAS = 3,
  localparam int CW   = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1,
  localparam int TMAX = (T_ABERTA > T_BLOQUEIO) ? T_ABERTA : T_BLOQUEIO,
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1,
  localparam int FW   = $clog2(MAX_FALHAS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CANAIS-1:0] cartao,
  input  logic                h,
  input  logic                p,
  output logic                F,
  output logic [CW-1:0]       canal,
  output logic                negado,
  output logic                bloqueado,
  output logic [1:0]          estado
);
  typedef enum logic [1:0] {
    FECHADA   = 2'b00,
    ABERTA    = 2'b01,
    BLOQUEADA = 2'b10
  } estado_t;

  localparam logic [TW-1:0] T_AB = TW'(T_ABERTA - 1);
  localparam logic [TW-1:0] T_BL = TW'(T_BLOQUEIO - 1);
  localparam logic [FW-1:0] MAXF = FW'(MAX_FALHAS);

  estado_t            st;
  logic [TW-1:0]      timer;
  logic [FW-1:0]      falhas;
  logic [FW-1:0]      falhas_inc;
  logic [N_CANAIS-1:0] ev;
  logic [CW-1:0]      sel;
  logic               any;

  controlador_porta_borda u_borda [N_CANAIS-1:0] (
    .clk   (clk),
    .rst   (rst),
    .nivel (cartao),
    .ev    (ev)
  );

  // lowest index wins; losing channels are simply dropped
  always_comb begin
    sel = '0;
    for (int i = N_CANAIS - 1; i >= 0; i--)
      if (ev[i]) sel = CW'(i);
  end

  assign any        = |ev;
  assign falhas_inc = falhas + FW'(1);
  assign estado     = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= FECHADA;
      timer     <= '0;
      falhas    <= '0;
      canal     <= '0;
      negado    <= 1'b0;
      F         <= 1'b0;
      bloqueado <= 1'b0;
    end else begin
      negado <= 1'b0;
      case (st)
        FECHADA: begin
          if (any) begin
            if (h) begin
              st     <= ABERTA;
              F      <= 1'b1;
              canal  <= sel;
              timer  <= T_AB;
              falhas <= '0;
            end else begin
              negado <= 1'b1;
              if (falhas_inc == MAXF) begin
                st        <= BLOQUEADA;
                bloqueado <= 1'b1;
                timer     <= T_BL;
                falhas    <= '0;
              end else begin
                falhas <= falhas_inc;
              end
            end
          end
        end
        ABERTA: begin
          if (p) begin
            timer <= T_AB;
          end else if (timer == '0) begin
            st <= FECHADA;
            F  <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        BLOQUEADA: begin
          // cards still get a denial pulse here but do not count toward lockout
          negado <= any;
          if (timer == '0) begin
            st        <= FECHADA;
            bloqueado <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          st        <= FECHADA;
          F         <= 1'b0;
          bloqueado <= 1'b0;
        end
      endcase
    end
  end
endmodule
